// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand bypass for the RV32I pipeline.
// Tracks in-flight register writes (entry 0 = EX, 1 = MEM, 2.. = later stages),
// resolves decode operands to the youngest in-flight value and raises stall for
// load-use hazards and slow memory reads.
module fwd_scoreboard #(
   parameter int XLEN  = 32,
   parameter int REGW  = 5,
   parameter int NSRC  = 2,
   parameter int DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid,
   input  logic [NSRC*REGW-1:0] id_rs,
   input  logic [NSRC*XLEN-1:0] id_rf_data,
   input  logic                 id_wen,
   input  logic [REGW-1:0]      id_rd,
   input  logic [1:0]           id_kind,
   input  logic [XLEN-1:0]      ex_result,
   input  logic [XLEN-1:0]      ex_pc4,
   input  logic [XLEN-1:0]      mem_rdata,
   input  logic                 mem_rvalid,
   input  logic                 flush,
   output logic                 stall,
   output logic [NSRC*XLEN-1:0] opnd,
   output logic [NSRC*4-1:0]    fwd_src
);

   localparam logic [1:0] K_LOAD = 2'd1;
   localparam logic [1:0] K_LINK = 2'd2;

   localparam logic [0:0] S_RUN     = 1'b0;
   localparam logic [0:0] S_MEMWAIT = 1'b1;

   // Entry state. Entry 0 carries no data (its value is still on the EX buses),
   // and only entries 0/1 need their kind: later entries are always resolved.
   logic [0:0]                 state;
   logic [DEPTH-1:0]           ent_v;
   logic [DEPTH-1:0][REGW-1:0] ent_rd;
   logic [1:0]                 ent_kind0, ent_kind1;
   logic [DEPTH-1:1]           ent_rdy;
   logic [DEPTH-1:1][XLEN-1:0] ent_data;

   // Effective value/readiness of each entry as seen from decode this cycle
   logic [DEPTH-1:0][XLEN-1:0] eff_val;
   logic [DEPTH-1:0]           eff_rdy;
   logic                       pend, freeze, luse_stall;
   logic [NSRC-1:0]            luse_v;

   // Entry values: EX from the EX buses, MEM bypasses arriving load data
   always_comb begin
      pend       = ent_v[1] & (ent_kind1 == K_LOAD) & ~ent_rdy[1];
      eff_val    = '0;
      eff_rdy    = '0;
      eff_val[0] = (ent_kind0 == K_LINK) ? ex_pc4 : ex_result;
      eff_rdy[0] = (ent_kind0 != K_LOAD);
      eff_val[1] = pend ? mem_rdata : ent_data[1];
      eff_rdy[1] = ent_rdy[1] | (pend & mem_rvalid);
      for (int k = 2; k < DEPTH; k++) begin
         eff_val[k] = ent_data[k];
         eff_rdy[k] = ent_rdy[k];
      end
   end

   // Per-operand youngest-match resolution
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      logic [REGW-1:0] rs;
      logic            hit, sel_rdy;
      logic [XLEN-1:0] sel_val;
      logic [3:0]      sel_src;

      // Scan oldest to youngest so the youngest match overwrites the rest
      always_comb begin
         rs      = id_rs[i*REGW +: REGW];
         hit     = 1'b0;
         sel_rdy = 1'b0;
         sel_val = '0;
         sel_src = '0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            if ((rs != '0) && ent_v[k] && (ent_rd[k] == rs)) begin
               hit     = 1'b1;
               sel_rdy = eff_rdy[k];
               sel_val = eff_val[k];
               sel_src = 4'(k + 1);
            end
         end
      end

      assign opnd[i*XLEN +: XLEN] = (hit & sel_rdy) ? sel_val : id_rf_data[i*XLEN +: XLEN];
      assign fwd_src[i*4 +: 4]    = (hit & sel_rdy) ? sel_src : 4'd0;
      assign luse_v[i]            = hit & ~sel_rdy;
   end

   // A pending load without data freezes the whole scoreboard
   assign freeze     = ((state == S_MEMWAIT) | pend) & ~mem_rvalid;
   assign luse_stall = id_valid & (|luse_v);
   assign stall      = freeze | luse_stall;

   // Scoreboard advance / freeze / bubble insertion
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_RUN;
         ent_v <= '0;
      end else begin
         state <= freeze ? S_MEMWAIT : S_RUN;
         if (!freeze) begin
            ent_v[1]    <= ent_v[0];
            ent_rd[1]   <= ent_rd[0];
            ent_kind1   <= ent_kind0;
            ent_rdy[1]  <= eff_rdy[0];
            ent_data[1] <= eff_val[0];
            for (int k = 2; k < DEPTH; k++) begin
               ent_v[k]    <= ent_v[k-1];
               ent_rd[k]   <= ent_rd[k-1];
               ent_rdy[k]  <= eff_rdy[k-1];
               ent_data[k] <= eff_val[k-1];
            end
            ent_v[0]  <= ~flush & ~luse_stall & id_valid & id_wen & (id_rd != '0);
            ent_rd[0] <= id_rd;
            ent_kind0 <= id_kind;
         end else if (flush) begin
            ent_v[0] <= 1'b0;
         end
      end
   end

endmodule
